// File: rtl/float_to_int_sat.sv
// Pipelined float-to-integer converter with saturation, per-sample rounding
// mode and exception flags. Four register stages share one advance enable,
// so a stalled consumer freezes the whole pipe and no sample is lost.
//
// Handshake: a sample moves in on a cycle where in_valid & in_ready, and a
// result moves out on a cycle where out_valid & out_ready. The pipe advances
// whenever the output register is empty or being drained (!out_valid |
// out_ready). A producer must hold in_data/in_round stable while in_valid is
// high and in_ready is low. While stalled, out_data and the flags hold.
//
// INT_SIZE must be at least MANTISSA_SIZE + 2.
module float_to_int_sat #(
    parameter int MANTISSA_SIZE        = 23,
    parameter int EXPONENT_SIZE        = 8,
    parameter int INT_SIZE             = 32,
    parameter int EXPONENT_BIAS_OFFSET = 0,
    parameter int SIGNED               = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   in_data,
    input  logic [1:0]                             in_round,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [INT_SIZE-1:0]                    out_data,
    output logic                                   out_overflow,
    output logic                                   out_invalid,
    output logic                                   out_inexact
);

    localparam int M  = MANTISSA_SIZE;
    localparam int ES = EXPONENT_SIZE;
    localparam int I  = INT_SIZE;
    localparam int DW = ES + M + 1;     // float width
    localparam int EW = ES + 2;         // signed unbiased exponent width
    localparam int MW = I + 1;          // shifted magnitude width
    localparam int RW = I + 2;          // rounded magnitude width (room for carry)
    localparam int XW = 2 * M + 3;      // right-shift window: significand + guard + sticky field

    localparam int              BIAS_INT = (1 << (ES - 1)) - 1 + EXPONENT_BIAS_OFFSET;
    localparam logic [EW-1:0]   BIAS_E   = BIAS_INT[EW-1:0];

    localparam logic [RW-1:0] ONE_R   = RW'(1);
    // Largest magnitude allowed for a positive / negative result.
    localparam logic [RW-1:0] POS_LIM = (SIGNED != 0) ? ((ONE_R << (I - 1)) - ONE_R)
                                                      : ((ONE_R << I) - ONE_R);
    localparam logic [RW-1:0] NEG_LIM = (SIGNED != 0) ? (ONE_R << (I - 1)) : {RW{1'b0}};
    localparam logic [I-1:0]  MAX_OUT = (SIGNED != 0) ? {1'b0, {(I-1){1'b1}}} : {I{1'b1}};
    localparam logic [I-1:0]  MIN_OUT = (SIGNED != 0) ? {1'b1, {(I-1){1'b0}}} : {I{1'b0}};

    logic adv;

    // Stage 1: field decode, classification, unbiased exponent
    logic                 sign_in;
    logic [ES-1:0]        exp_in;
    logic [M-1:0]         mant_in;
    logic signed [EW-1:0] e1_d;
    logic                 nan1_d, inf1_d, zero1_d;

    logic                 v1_q, sign1_q, nan1_q, inf1_q, zero1_q;
    logic [1:0]           rnd1_q;
    logic [M-1:0]         mant1_q;
    logic signed [EW-1:0] e1_q;

    // Stage 2: aligned magnitude with guard/sticky
    int                   e_int;
    logic [XW-1:0]        ext;
    logic [XW-1:0]        shifted;
    logic [MW-1:0]        mag2_d;
    logic                 guard2_d, sticky2_d, big2_d;

    logic                 v2_q, sign2_q, nan2_q, inf2_q, big2_q, guard2_q, sticky2_q;
    logic [1:0]           rnd2_q;
    logic [MW-1:0]        mag2_q;

    // Stage 3: rounded magnitude
    logic                 inc3;
    logic [RW-1:0]        mag3_d;
    logic                 inexact3_d;

    logic                 v3_q, sign3_q, nan3_q, inf3_q, big3_q, inexact3_q;
    logic [RW-1:0]        mag3_q;

    // Stage 4: range check and saturation into the output register
    logic [I-1:0]         data4_d;
    logic                 ovf4_d, inv4_d, inx4_d;

    logic                 out_valid_q, ovf_q, inv_q, inx_q;
    logic [I-1:0]         out_data_q;

    assign adv      = !out_valid_q | out_ready;
    assign in_ready = adv & !reset;

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_overflow = ovf_q;
    assign out_invalid  = inv_q;
    assign out_inexact  = inx_q;

    // Split the float and classify it; exponent is unbiased in EW-bit signed arithmetic
    always_comb begin
        sign_in = in_data[DW-1];
        exp_in  = in_data[DW-2:M];
        mant_in = in_data[M-1:0];
        e1_d    = $signed({2'b00, exp_in}) - $signed(BIAS_E);
        nan1_d  = (&exp_in) & (|mant_in);
        inf1_d  = (&exp_in) & ~(|mant_in);
        zero1_d = ~(|exp_in);
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            rnd1_q  <= 2'b00;
            mant1_q <= '0;
            e1_q    <= '0;
        end else if (adv) begin
            v1_q    <= in_valid & in_ready;
            sign1_q <= sign_in;
            nan1_q  <= nan1_d;
            inf1_q  <= inf1_d;
            zero1_q <= zero1_d;
            rnd1_q  <= in_round;
            mant1_q <= mant_in;
            e1_q    <= e1_d;
        end
    end

    // Align the significand: left shift for large exponents, right shift with guard/sticky otherwise
    always_comb begin
        e_int     = int'(e1_q);
        ext       = {1'b1, mant1_q, {(M+2){1'b0}}};
        shifted   = '0;
        mag2_d    = '0;
        guard2_d  = 1'b0;
        sticky2_d = 1'b0;
        big2_d    = 1'b0;
        if (nan1_q | inf1_q) begin
            // handled at the range stage
        end else if (zero1_q) begin
            // zero/denormal: magnitude below one half
            sticky2_d = |mant1_q;
        end else if (e_int >= I + 1) begin
            // too large for the shifter; always saturates
            big2_d = 1'b1;
        end else if (e_int >= M) begin
            mag2_d = MW'({1'b1, mant1_q}) << (e_int - M);
        end else if (M - e_int >= M + 2) begin
            // every significand bit lies below the guard position
            sticky2_d = 1'b1;
        end else begin
            shifted   = ext >> (M - e_int);
            mag2_d    = MW'(shifted[XW-1:M+2]);
            guard2_d  = shifted[M+1];
            sticky2_d = |shifted[M:0];
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q      <= 1'b0;
            sign2_q   <= 1'b0;
            nan2_q    <= 1'b0;
            inf2_q    <= 1'b0;
            big2_q    <= 1'b0;
            guard2_q  <= 1'b0;
            sticky2_q <= 1'b0;
            rnd2_q    <= 2'b00;
            mag2_q    <= '0;
        end else if (adv) begin
            v2_q      <= v1_q;
            sign2_q   <= sign1_q;
            nan2_q    <= nan1_q;
            inf2_q    <= inf1_q;
            big2_q    <= big2_d;
            guard2_q  <= guard2_d;
            sticky2_q <= sticky2_d;
            rnd2_q    <= rnd1_q;
            mag2_q    <= mag2_d;
        end
    end

    // Apply the sample's rounding mode to the magnitude
    always_comb begin
        case (rnd2_q)
            2'b01:   inc3 = 1'b0;                                   // toward zero
            2'b10:   inc3 = guard2_q;                               // nearest, ties away
            default: inc3 = guard2_q & (sticky2_q | mag2_q[0]);     // nearest, ties even
        endcase
        mag3_d     = RW'(mag2_q) + RW'(inc3);
        inexact3_d = guard2_q | sticky2_q;
    end

    // Stage 3 register
    always_ff @(posedge clk) begin
        if (reset) begin
            v3_q       <= 1'b0;
            sign3_q    <= 1'b0;
            nan3_q     <= 1'b0;
            inf3_q     <= 1'b0;
            big3_q     <= 1'b0;
            inexact3_q <= 1'b0;
            mag3_q     <= '0;
        end else if (adv) begin
            v3_q       <= v2_q;
            sign3_q    <= sign2_q;
            nan3_q     <= nan2_q;
            inf3_q     <= inf2_q;
            big3_q     <= big2_q;
            inexact3_q <= inexact3_d;
            mag3_q     <= mag3_d;
        end
    end

    // Range check on the rounded, signed value; flags priority invalid > overflow > inexact
    always_comb begin
        data4_d = '0;
        ovf4_d  = 1'b0;
        inv4_d  = 1'b0;
        inx4_d  = 1'b0;
        if (nan3_q) begin
            data4_d = MAX_OUT;
            inv4_d  = 1'b1;
        end else if (inf3_q | big3_q) begin
            data4_d = sign3_q ? MIN_OUT : MAX_OUT;
            ovf4_d  = 1'b1;
        end else if (!sign3_q) begin
            if (mag3_q > POS_LIM) begin
                data4_d = MAX_OUT;
                ovf4_d  = 1'b1;
            end else begin
                data4_d = mag3_q[I-1:0];
                inx4_d  = inexact3_q;
            end
        end else begin
            if (mag3_q > NEG_LIM) begin
                data4_d = MIN_OUT;
                ovf4_d  = 1'b1;
            end else begin
                data4_d = -mag3_q[I-1:0];
                inx4_d  = inexact3_q;
            end
        end
    end

    // Output register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v3_q;
            out_data_q  <= data4_d;
            ovf_q       <= ovf4_d;
            inv_q       <= inv4_d;
            inx_q       <= inx4_d;
        end
    end

endmodule

// File: tb/tb_float_to_int_sat.sv
// Bench for float_to_int_sat: three instances (signed, unsigned, fixed-point
// scale by 2) share one input stream and one out_ready; each has its own
// expected-result queue filled by an independent reference model or by
// directed constants.
module tb_float_to_int_sat;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_round = 2'b00;
  logic        out_ready = 1'b1;

  logic        rdy_s, rdy_u, rdy_o;
  logic        ov_s, ov_u, ov_o;
  logic [31:0] od_s, od_u, od_o;
  logic        ovf_s, ovf_u, ovf_o;
  logic        inv_s, inv_u, inv_o;
  logic        inx_s, inx_u, inx_o;

  float_to_int_sat #(.SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .in_round(in_round), .out_valid(ov_s), .out_ready(out_ready),
    .out_data(od_s), .out_overflow(ovf_s), .out_invalid(inv_s), .out_inexact(inx_s)
  );

  float_to_int_sat #(.SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_u),
    .in_data(in_data), .in_round(in_round), .out_valid(ov_u), .out_ready(out_ready),
    .out_data(od_u), .out_overflow(ovf_u), .out_invalid(inv_u), .out_inexact(inx_u)
  );

  float_to_int_sat #(.SIGNED(1), .EXPONENT_BIAS_OFFSET(-1)) dut_o (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o),
    .in_data(in_data), .in_round(in_round), .out_valid(ov_o), .out_ready(out_ready),
    .out_data(od_o), .out_overflow(ovf_o), .out_invalid(inv_o), .out_inexact(inx_o)
  );

  logic [34:0] got [3];
  logic        ov  [3];
  logic        rdy [3];
  assign got[0] = {od_s, ovf_s, inv_s, inx_s};
  assign got[1] = {od_u, ovf_u, inv_u, inx_u};
  assign got[2] = {od_o, ovf_o, inv_o, inx_o};
  assign ov[0] = ov_s;
  assign ov[1] = ov_u;
  assign ov[2] = ov_o;
  assign rdy[0] = rdy_s;
  assign rdy[1] = rdy_u;
  assign rdy[2] = rdy_o;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;

  logic [34:0] exp_s_q[$];
  logic [34:0] exp_u_q[$];
  logic [34:0] exp_o_q[$];

  string dut_name [3] = '{"signed", "unsigned", "offset"};

  bit   lat_armed = 1'b0;
  int   lat_start = 0;
  int   first_acc = -1000;
  int   or_mode = 0;   // 0: always ready, 1: random, 2: fixed stall window

  logic        stall_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic [34:0] held [3];

  task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  // Reference conversion for float32 -> 32-bit, written as exact
  // quotient/remainder arithmetic. Result packed as {data, ovf, inv, inx}.
  function automatic logic [34:0] ref_convert(input logic [31:0] f, input logic [1:0] rm,
                                              input bit sgn_mode, input int off);
    longint sig, ip, rem, half, v;
    int     ef, e, sh;
    bit     s, up, ovf, inx;
    logic [31:0] d;
    s    = f[31];
    ef   = int'(f[30:23]);
    sig  = longint'({1'b1, f[22:0]});
    ip   = 0;
    rem  = 0;
    half = 1;
    ovf  = 1'b0;
    d    = '0;
    if (ef == 255 && f[22:0] != 0)
      return {(sgn_mode ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 3'b010};
    if (ef == 255) begin
      ip = longint'(1) << 40;
    end else if (ef == 0) begin
      rem  = (f[22:0] != 0) ? 1 : 0;
      half = 2;
    end else begin
      e = ef - 127 - off;
      if (e >= 40) ip = longint'(1) << 40;
      else if (e >= 23) ip = sig << (e - 23);
      else begin
        sh = 23 - e;
        if (sh >= 40) begin
          rem  = 1;
          half = longint'(1) << 39;
        end else begin
          ip   = sig >> sh;
          rem  = sig & ((longint'(1) << sh) - 1);
          half = longint'(1) << (sh - 1);
        end
      end
    end
    case (rm)
      2'b01:   up = 1'b0;
      2'b10:   up = (rem >= half);
      default: up = (rem > half) || (rem == half && ip[0]);
    endcase
    if (up) ip = ip + 1;
    inx = (rem != 0);
    if (sgn_mode) begin
      v = s ? -ip : ip;
      if (v > 64'sd2147483647) begin d = 32'h7FFF_FFFF; ovf = 1'b1; end
      else if (v < -64'sd2147483648) begin d = 32'h8000_0000; ovf = 1'b1; end
      else d = v[31:0];
    end else begin
      if (s && ip != 0) begin d = 32'h0; ovf = 1'b1; end
      else if (ip > 64'sd4294967295) begin d = 32'hFFFF_FFFF; ovf = 1'b1; end
      else d = ip[31:0];
    end
    if (ovf) inx = 1'b0;
    return {d, ovf, 1'b0, inx};
  endfunction

  // ---------------- driver tasks ----------------
  // Present one sample; when it is accepted, push the expectations.
  // sel picks an instance whose expectation comes from dexp instead of the model.
  task automatic send(input logic [31:0] d, input logic [1:0] rm, input int sel,
                      input logic [34:0] dexp, input bit arm);
    bit ok;
    logic [34:0] e0, e1, e2;
    in_valid = 1'b1;
    in_data  = d;
    in_round = rm;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rdy_s && !reset) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_eq("accept_timeout", ok, 1);
      in_valid = 1'b0;
      return;
    end
    e0 = ref_convert(d, rm, 1'b1, 0);
    e1 = ref_convert(d, rm, 1'b0, 0);
    e2 = ref_convert(d, rm, 1'b1, -1);
    if (sel == 0) e0 = dexp;
    if (sel == 1) e1 = dexp;
    if (sel == 2) e2 = dexp;
    exp_s_q.push_back(e0);
    exp_u_q.push_back(e1);
    exp_o_q.push_back(e2);
    if (arm) begin
      lat_armed = 1'b1;
      lat_start = cyc;
      first_acc = cyc;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_s_q.size() + exp_u_q.size() + exp_o_q.size()) != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain", exp_s_q.size() + exp_u_q.size() + exp_o_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input int idx, input logic [34:0] g);
    int sz;
    logic [34:0] e;
    case (idx)
      0:       sz = exp_s_q.size();
      1:       sz = exp_u_q.size();
      default: sz = exp_o_q.size();
    endcase
    check_eq({dut_name[idx], "_out_expected"}, sz != 0, 1);
    if (sz != 0) begin
      case (idx)
        0:       e = exp_s_q.pop_front();
        1:       e = exp_u_q.pop_front();
        default: e = exp_o_q.pop_front();
      endcase
      check_eq({dut_name[idx], "_result"}, g, e);
    end
  endtask

  // ---------------- out_ready generator ----------------
  initial begin
    int d;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          d = cyc - first_acc;
          out_ready = !(d >= 5 && d <= 8);
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) stall_prev[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        check_eq({dut_name[i], "_in_ready"}, rdy[i], !(ov[i] && !out_ready));
        if (stall_prev[i]) check_eq({dut_name[i], "_stall_hold"}, {ov[i], got[i]}, {1'b1, held[i]});
        if (ov[i] && out_ready) pop_cmp(i, got[i]);
        stall_prev[i] = ov[i] && !out_ready;
        held[i] = got[i];
      end
      if (lat_armed && ov[0]) begin
        check_eq("latency", cyc - lat_start, 4);
        lat_armed = 1'b0;
      end else if (lat_armed && (cyc - lat_start) > 20) begin
        check_eq("latency_timeout", ov[0], 1);
        lat_armed = 1'b0;
      end
    end
  end

  // ---------------- directed vectors ----------------
  localparam int ND = 21;
  logic [31:0] dir_data [ND] = '{
    32'h4020_0000, 32'h4020_0000, 32'h4020_0000, 32'hC060_0000, 32'h3F00_0000,
    32'h3F00_0000, 32'h0000_0001, 32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000,
    32'h7FC0_0000, 32'hBF80_0000, 32'hBE80_0000, 32'h4F80_0000, 32'h3FC0_0000,
    32'h7F80_0000, 32'h3FC0_0000, 32'h4EFF_FFFF, 32'h7FC0_0000, 32'hC020_0000,
    32'hBF00_0000};
  logic [1:0]  dir_rm   [ND] = '{
    2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd2};
  int          dir_sel  [ND] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 1, 1, 1, 2, 0, 0, 0, 1, 0, 1};
  logic [31:0] dir_res  [ND] = '{
    32'd2, 32'd2, 32'd3, 32'hFFFF_FFFC, 32'd0,
    32'd1, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
    32'h7FFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3,
    32'h7FFF_FFFF, 32'd2, 32'h7FFF_FF80, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
    32'd0};
  logic [2:0]  dir_flg  [ND] = '{   // {overflow, invalid, inexact}
    3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
    3'b001, 3'b001, 3'b100, 3'b000, 3'b100,
    3'b010, 3'b100, 3'b001, 3'b100, 3'b000,
    3'b100, 3'b001, 3'b000, 3'b010, 3'b001,
    3'b100};

  logic [31:0] ramp [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                            32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] f;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq({dut_name[i], "_rst_in_ready"}, rdy[i], 0);
      check_eq({dut_name[i], "_rst_out_valid"}, ov[i], 0);
      check_eq({dut_name[i], "_rst_out"}, got[i], 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // directed values with hand-derived results
    for (int i = 0; i < ND; i++)
      send(dir_data[i], dir_rm[i], dir_sel[i], {dir_res[i], dir_flg[i]}, i == 0);
    drain();

    // back-to-back 1.0..8.0 with a stall window after the first accept
    or_mode = 2;
    for (int k = 0; k < 8; k++)
      send(ramp[k], 2'b00, 0, {32'(k + 1), 3'b000}, k == 0);
    drain();
    or_mode = 0;
    first_acc = -1000;

    // reset with three samples in flight
    for (int k = 0; k < 3; k++) send(ramp[k + 3], 2'b00, -1, '0, 1'b0);
    reset = 1'b1;
    exp_s_q.delete();
    exp_u_q.delete();
    exp_o_q.delete();
    lat_armed = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq({dut_name[i], "_post_rst_valid"}, ov[i], 0);
      check_eq({dut_name[i], "_post_rst_data"}, got[i][34:3], 0);
    end
    @(posedge clk);
    #1;
    send(32'h4120_0000, 2'b00, 0, {32'd10, 3'b000}, 1'b1);
    drain();

    // random stream with random backpressure and idle gaps
    or_mode = 1;
    for (int n = 0; n < 250; n++) begin
      f[31] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       f[30:23] = 8'hFF;
        1:       f[30:23] = 8'h00;
        default: f[30:23] = 8'($urandom_range(110, 162));
      endcase
      f[22:0] = 23'($urandom);
      if ($urandom_range(0, 15) == 0) f[22:0] = '0;
      send(f, 2'($urandom_range(0, 3)), -1, '0, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    or_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
